// File: rtl/enum_seq_decoder_if.sv
// rtl/enum_seq_decoder_if.sv - symbol input and event output handshake bundle for the enum sequence decoder
interface enum_seq_decoder_if #(
  parameter int SYM_W = 32
);
  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym_data;
  logic             evt_valid;
  logic             evt_ready;
  logic [2:0]       evt_code;

  // Symbol source and event consumer side
  modport master (
    output sym_valid, sym_data, evt_ready,
    input  sym_ready, evt_valid, evt_code
  );

  // Decoder side
  modport slave (
    input  sym_valid, sym_data, evt_ready,
    output sym_ready, evt_valid, evt_code
  );
endinterface

// File: rtl/enum_seq_decoder.sv
// rtl/enum_seq_decoder.sv - frame order checker for the START/SEQ/STOP enum symbol stream
module enum_seq_decoder #(
  parameter int SEQ_LEN  = 3,
  parameter int STOP_VAL = 100,
  parameter int SYM_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  enum_seq_decoder_if.slave              bus,
  output logic [$clog2(SEQ_LEN+1)-1:0]   seq_idx,
  output logic [15:0]                    frame_count,
  output logic                           busy
);
  localparam int IDX_W = $clog2(SEQ_LEN + 1);

  localparam logic [2:0] EV_DONE    = 3'd0;
  localparam logic [2:0] EV_UNEXP   = 3'd1;
  localparam logic [2:0] EV_SHORT   = 3'd2;
  localparam logic [2:0] EV_ORDER   = 3'd3;
  localparam logic [2:0] EV_LONG    = 3'd4;
  localparam logic [2:0] EV_RESTART = 3'd5;

  // STOP must not collide with any SEQ encoding, otherwise decode is ambiguous
  if (SEQ_LEN < 1) begin : g_bad_seq_len
    $error("enum_seq_decoder: SEQ_LEN must be at least 1");
  end
  if (STOP_VAL <= SEQ_LEN) begin : g_bad_stop_val
    $error("enum_seq_decoder: STOP_VAL must exceed SEQ_LEN");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEQ,
    S_EXPECT_STOP
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [15:0]      frame_count_q, frame_count_n;
  logic             evt_valid_q, evt_valid_n;
  logic [2:0]       evt_code_q, evt_code_n;

  logic accept;
  logic is_start;
  logic is_stop;
  logic is_expected;
  logic is_last;

  // A symbol can only be taken when the event register is free or being drained
  assign bus.sym_ready = !evt_valid_q || bus.evt_ready;
  assign accept        = bus.sym_valid && bus.sym_ready;

  // Full-width unsigned decode: stray upper bits turn a symbol into OTHER
  assign is_start    = (bus.sym_data == '0);
  assign is_stop     = (bus.sym_data == SYM_W'(STOP_VAL));
  assign is_expected = (bus.sym_data == (SYM_W'(idx_q) + SYM_W'(1)));
  assign is_last     = (idx_q == IDX_W'(SEQ_LEN - 1));

  // Next-state, sequence index, frame counter and event register contents
  always_comb begin
    state_n       = state;
    idx_n         = idx_q;
    frame_count_n = frame_count_q;
    evt_valid_n   = evt_valid_q && !bus.evt_ready;
    evt_code_n    = evt_code_q;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (is_start) begin
            state_n = S_SEQ;
            idx_n   = '0;
          end else begin
            evt_valid_n = 1'b1;
            evt_code_n  = EV_UNEXP;
          end
        end
        S_SEQ: begin
          if (is_start) begin
            idx_n       = '0;
            evt_valid_n = 1'b1;
            evt_code_n  = EV_RESTART;
          end else if (is_expected) begin
            idx_n = idx_q + IDX_W'(1);
            if (is_last) begin
              state_n = S_EXPECT_STOP;
            end
          end else if (is_stop) begin
            state_n     = S_IDLE;
            idx_n       = '0;
            evt_valid_n = 1'b1;
            evt_code_n  = EV_SHORT;
          end else begin
            state_n     = S_IDLE;
            idx_n       = '0;
            evt_valid_n = 1'b1;
            evt_code_n  = EV_ORDER;
          end
        end
        S_EXPECT_STOP: begin
          if (is_stop) begin
            state_n     = S_IDLE;
            idx_n       = '0;
            evt_valid_n = 1'b1;
            evt_code_n  = EV_DONE;
            if (frame_count_q != 16'hFFFF) begin
              frame_count_n = frame_count_q + 16'd1;
            end
          end else if (is_start) begin
            state_n     = S_SEQ;
            idx_n       = '0;
            evt_valid_n = 1'b1;
            evt_code_n  = EV_RESTART;
          end else begin
            state_n     = S_IDLE;
            idx_n       = '0;
            evt_valid_n = 1'b1;
            evt_code_n  = EV_LONG;
          end
        end
        default: begin
          state_n = S_IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  // State and event registers; reset drops any frame in progress and any pending event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx_q         <= '0;
      frame_count_q <= '0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= 3'd0;
    end else begin
      state         <= state_n;
      idx_q         <= idx_n;
      frame_count_q <= frame_count_n;
      evt_valid_q   <= evt_valid_n;
      evt_code_q    <= evt_code_n;
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign seq_idx       = idx_q;
  assign frame_count   = frame_count_q;
  assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_enum_seq_decoder.sv
// tb/tb_enum_seq_decoder.sv - self-checking bench for enum_seq_decoder
module tb_enum_seq_decoder;
  localparam int SEQ_LEN  = 3;
  localparam int STOP_VAL = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  seq_idx;
  logic [15:0] frame_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: symbols of the frame in progress, event slot, frame total
  int m_frame[$];
  int m_count;
  bit m_ev_valid;
  int m_ev_code;

  always #5 clk = ~clk;

  enum_seq_decoder_if #(.SYM_W(32)) bus_if ();

  enum_seq_decoder #(
    .SEQ_LEN (SEQ_LEN),
    .STOP_VAL(STOP_VAL),
    .SYM_W   (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .seq_idx    (seq_idx),
    .frame_count(frame_count),
    .busy       (busy)
  );

  function automatic void reset_model();
    m_frame.delete();
    m_count    = 0;
    m_ev_valid = 1'b0;
    m_ev_code  = 0;
  endfunction

  function automatic void post_event(input int code);
    m_ev_valid = 1'b1;
    m_ev_code  = code;
  endfunction

  // Frame is expected to read 0, 1..SEQ_LEN, STOP_VAL; position = symbols seen so far
  function automatic void model_accept(input logic [31:0] s);
    int n;
    n = m_frame.size();
    if (n == 0) begin
      if (s == 0) m_frame.push_back(0);
      else post_event(1);
    end else if (s == 0) begin
      m_frame.delete();
      m_frame.push_back(0);
      post_event(5);
    end else if (n <= SEQ_LEN) begin
      if (s == n) m_frame.push_back(n);
      else begin
        post_event((s == STOP_VAL) ? 2 : 3);
        m_frame.delete();
      end
    end else begin
      if (s == STOP_VAL) begin
        post_event(0);
        if (m_count < 65535) m_count++;
      end else begin
        post_event(4);
      end
      m_frame.delete();
    end
  endfunction

  function automatic int model_idx();
    return (m_frame.size() == 0) ? 0 : m_frame.size() - 1;
  endfunction

  function automatic logic [31:0] model_next_sym();
    int n;
    n = m_frame.size();
    if (n == 0) return 32'd0;
    if (n <= SEQ_LEN) return 32'(n);
    return 32'(STOP_VAL);
  endfunction

  function automatic logic [22:0] snap();
    return {bus_if.evt_valid, bus_if.evt_code & {3{bus_if.evt_valid}}, seq_idx, busy, frame_count};
  endfunction

  function automatic logic [22:0] pack(input bit v, input int code, input int idx, input bit b, input int cnt);
    return {v, v ? 3'(code) : 3'd0, 2'(idx), b, 16'(cnt)};
  endfunction

  task automatic drive(input bit v, input logic [31:0] d, input bit r);
    bus_if.sym_valid = v;
    bus_if.sym_data  = d;
    bus_if.evt_ready = r;
    #1;
  endtask

  task automatic tick();
    bit exp_ready;
    exp_ready = !m_ev_valid || bus_if.evt_ready;
    if (m_ev_valid && bus_if.evt_ready) m_ev_valid = 1'b0;
    if (bus_if.sym_valid && exp_ready && rst_n) model_accept(bus_if.sym_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d);
    drive(1'b1, d, 1'b1);
    tick();
    bus_if.sym_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] exp;
    exp = pack(0, 0, 0, 0, 0);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", snap(), exp);
    end
    checks++;
    if (bus_if.evt_code !== 3'd0) begin
      failures++;
      $display("FAIL reset_evt_code: got %0d want 0", bus_if.evt_code);
    end
    checks++;
    if (bus_if.sym_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_sym_ready: got %b want 1", bus_if.sym_ready);
    end
  endtask

  task automatic test_good_frame();
    logic [22:0] exp;
    for (int i = 0; i <= SEQ_LEN; i++) begin
      send(32'(i));
      exp = pack(0, 0, i, 1, 0);
      checks++;
      if (snap() !== exp) begin
        failures++;
        $display("FAIL good_sym%0d: got %h want %h", i, snap(), exp);
      end
    end
    send(32'(STOP_VAL));
    exp = pack(1, 0, 0, 0, 1);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL good_done: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_backpressure();
    logic [22:0] exp;
    drive(1'b1, 32'd0, 1'b0);
    checks++;
    if (bus_if.sym_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_low: got %b want 0", bus_if.sym_ready);
    end
    tick();
    exp = pack(1, 0, 0, 0, 1);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL bp_held: got %h want %h", snap(), exp);
    end
    drive(1'b1, 32'd0, 1'b1);
    checks++;
    if (bus_if.sym_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_high: got %b want 1", bus_if.sym_ready);
    end
    tick();
    bus_if.sym_valid = 1'b0;
    exp = pack(0, 0, 0, 1, 1);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL bp_accept: got %h want %h", snap(), exp);
    end
    for (int i = 1; i <= SEQ_LEN; i++) send(32'(i));
    send(32'(STOP_VAL));
    exp = pack(1, 0, 0, 0, 2);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL bp_done: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_short_order();
    logic [22:0] exp;
    send(32'd0);
    send(32'd1);
    send(32'(STOP_VAL));
    exp = pack(1, 2, 0, 0, 2);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL short_evt: got %h want %h", snap(), exp);
    end
    send(32'd0);
    send(32'd2);
    exp = pack(1, 3, 0, 0, 2);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL order_evt: got %h want %h", snap(), exp);
    end
    send(32'd5);
    exp = pack(1, 1, 0, 0, 2);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL unexp_evt: got %h want %h", snap(), exp);
    end
    send(32'd0);
    send(32'h8000_0001);
    exp = pack(1, 3, 0, 0, 2);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL upper_bits_order: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_restart_long();
    logic [22:0] exp;
    send(32'd0);
    send(32'd1);
    send(32'd0);
    exp = pack(1, 5, 0, 1, 2);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL restart_in_seq: got %h want %h", snap(), exp);
    end
    for (int i = 1; i <= SEQ_LEN; i++) send(32'(i));
    send(32'(STOP_VAL));
    exp = pack(1, 0, 0, 0, 3);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL restart_done: got %h want %h", snap(), exp);
    end
    for (int i = 0; i <= SEQ_LEN; i++) send(32'(i));
    send(32'(SEQ_LEN));
    exp = pack(1, 4, 0, 0, 3);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL long_evt: got %h want %h", snap(), exp);
    end
    for (int i = 0; i <= SEQ_LEN; i++) send(32'(i));
    send(32'd0);
    exp = pack(1, 5, 0, 1, 3);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL restart_at_stop: got %h want %h", snap(), exp);
    end
    for (int i = 1; i <= SEQ_LEN; i++) send(32'(i));
    send(32'(STOP_VAL));
    exp = pack(1, 0, 0, 0, 4);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL restart_at_stop_done: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_saturation();
    logic [22:0] exp;
    drive(1'b0, 32'd0, 1'b1);
    force dut.frame_count_q = 16'hFFFD;
    tick();
    release dut.frame_count_q;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i <= SEQ_LEN; i++) send(32'(i));
      send(32'(STOP_VAL));
      exp = pack(1, 0, 0, 0, (f == 0) ? 16'hFFFE : 16'hFFFF);
      checks++;
      if (snap() !== exp) begin
        failures++;
        $display("FAIL saturate_frame%0d: got %h want %h", f, snap(), exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [22:0] exp;
    send(32'd0);
    send(32'd1);
    rst_n = 1'b0;
    #1;
    exp = pack(0, 0, 0, 0, 0);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL midreset_state: got %h want %h", snap(), exp);
    end
    tick();
    rst_n = 1'b1;
    reset_model();
    for (int i = 0; i <= SEQ_LEN; i++) send(32'(i));
    send(32'(STOP_VAL));
    exp = pack(1, 0, 0, 0, 1);
    checks++;
    if (snap() !== exp) begin
      failures++;
      $display("FAIL midreset_done: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_random();
    logic [22:0] exp;
    logic [31:0] d;
    bit          v;
    bit          r;
    int          bad;
    bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    reset_model();
    for (int c = 0; c < 3000; c++) begin
      exp = pack(m_ev_valid, m_ev_code, model_idx(), m_frame.size() != 0, m_count);
      checks++;
      if (snap() !== exp) begin
        failures++;
        $display("FAIL random_state c=%0d: got %h want %h", c, snap(), exp);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: d = model_next_sym();
        6:                d = 32'd0;
        7:                d = 32'($urandom_range(1, SEQ_LEN));
        8:                d = 32'(STOP_VAL);
        default:          d = $urandom;
      endcase
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      drive(v, d, r);
      checks++;
      if (bus_if.sym_ready !== (!m_ev_valid || r)) begin
        failures++;
        $display("FAIL random_ready c=%0d: got %b want %b", c, bus_if.sym_ready, !m_ev_valid || r);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    reset_model();
    drive(1'b0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_good_frame();
    test_backpressure();
    test_short_order();
    test_restart_long();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
